router_arb: RTL and testbench

ROUTER_ARB -- requirements
Module: router_arb

---
 rtl/router_arb.sv | 120 ++++++++++++
 tb/tb_router_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_arb.sv
// rtl/router_arb.sv - round-robin N-source write arbiter feeding a one-entry data-bank output register
//
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   req_valid[NSRC]      per-source write request
//   req_data[NSRC*W]     per-source write data, source i at [i*W +: W]
//   req_addr[NSRC*ADDRW] per-source write address, source i at [i*ADDRW +: ADDRW]
//   req_ready[NSRC]      one-hot combinational accept
//   db_ready             data bank takes the presented write this cycle
//   db_data, db_dira     registered write data / address
//   db_write             registered write strobe (high while a transaction is pending)
//   grant_id             registered index of the source owning the pending transaction
//
// Build option: ROUTER_ARB_PRIO0_EN gives source 0 fixed top priority;
// round-robin then applies among sources 1..NSRC-1 only.

module router_arb #(
    parameter int W     = 24,
    parameter int ADDRW = 5,
    parameter int NSRC  = 4,
    parameter int IDW   = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NSRC-1:0]        req_valid,
    input  logic [NSRC*W-1:0]      req_data,
    input  logic [NSRC*ADDRW-1:0]  req_addr,
    output logic [NSRC-1:0]        req_ready,
    input  logic                   db_ready,
    output logic [W-1:0]           db_data,
    output logic [ADDRW-1:0]       db_dira,
    output logic                   db_write,
    output logic [IDW-1:0]         grant_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;

    logic           found;
    int             gnt_int;
    logic           accept;

    // Grant search: first valid source at or after ptr, wrapping.
    always_comb begin
        int idx;
        found   = 1'b0;
        gnt_int = 0;
        idx     = 0;
`ifdef ROUTER_ARB_PRIO0_EN
        if (req_valid[0]) begin
            found   = 1'b1;
            gnt_int = 0;
        end
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!found && idx != 0 && req_valid[idx]) begin
                found   = 1'b1;
                gnt_int = idx;
            end
        end
`else
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_int = idx;
            end
        end
`endif
    end

    // Register may load when empty or when its current contents leave this edge.
    assign accept = RST_N && found && ((state == EMPTY) || db_ready);

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_int] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (accept) begin
            state_nxt = FULL;
            ptr_nxt   = (gnt_int + 1 >= NSRC) ? '0 : IDW'(gnt_int + 1);
        end else if (state == FULL && db_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= EMPTY;
            ptr      <= '0;
            db_data  <= '0;
            db_dira  <= '0;
            grant_id <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (accept) begin
                db_data  <= req_data[gnt_int*W +: W];
                db_dira  <= req_addr[gnt_int*ADDRW +: ADDRW];
                grant_id <= IDW'(gnt_int);
            end
        end
    end

    assign db_write = (state == FULL);

endmodule

// File: tb/tb_router_arb.sv
// tb/tb_router_arb.sv - directed self-checking bench for router_arb

module tb_router_arb;

    localparam int W     = 24;
    localparam int ADDRW = 5;
    localparam int NSRC  = 4;
    localparam int IDW   = 2;

    logic                  CLK;
    logic                  RST_N;
    logic [NSRC-1:0]       req_valid;
    logic [NSRC*W-1:0]     req_data;
    logic [NSRC*ADDRW-1:0] req_addr;
    logic [NSRC-1:0]       req_ready;
    logic                  db_ready;
    logic [W-1:0]          db_data;
    logic [ADDRW-1:0]      db_dira;
    logic                  db_write;
    logic [IDW-1:0]        grant_id;

    int checks   = 0;
    int failures = 0;

    router_arb #(.W(W), .ADDRW(ADDRW), .NSRC(NSRC), .IDW(IDW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .db_ready  (db_ready),
        .db_data   (db_data),
        .db_dira   (db_dira),
        .db_write  (db_write),
        .grant_id  (grant_id)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] sdata(input int i);
        return 24'hA5_0000 + 24'(i * 17);
    endfunction

    function automatic logic [ADDRW-1:0] saddr(input int i);
        return 5'(8 + i);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_sources();
        for (int i = 0; i < NSRC; i++) begin
            req_data[i*W +: W]         = sdata(i);
            req_addr[i*ADDRW +: ADDRW] = saddr(i);
        end
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        req_valid = '0;
        db_ready  = 1'b0;
        step();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        req_valid = 4'b1111;
        db_ready  = 1'b1;
        load_sources();
        step();
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
        end
        step();
        checks++;
        if (db_write !== 1'b0 || db_data !== '0 || db_dira !== '0 || grant_id !== '0) begin
            failures++;
            $display("FAIL reset_outputs got write=%b data=%h dira=%h gid=%0d exp 0/0/0/0",
                     db_write, db_data, db_dira, grant_id);
        end
        req_valid = '0;
        RST_N     = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_valid                  = 4'b0100;
        req_data[2*W +: W]         = 24'hC0FFEE;
        req_addr[2*ADDRW +: ADDRW] = 5'h12;
        db_ready                   = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_req_ready got=%b exp=0100", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (db_write !== 1'b1 || db_data !== 24'hC0FFEE || db_dira !== 5'h12 || grant_id !== 2'd2) begin
            failures++;
            $display("FAIL single_out got write=%b data=%h dira=%h gid=%0d exp 1/c0ffee/12/2",
                     db_write, db_data, db_dira, grant_id);
        end
        step();
        checks++;
        if (db_write !== 1'b0 || db_data !== 24'hC0FFEE || db_dira !== 5'h12 || grant_id !== 2'd2) begin
            failures++;
            $display("FAIL single_drain got write=%b data=%h dira=%h gid=%0d exp 0/c0ffee/12/2",
                     db_write, db_data, db_dira, grant_id);
        end
        load_sources();
    endtask

    task automatic test_back_to_back();
        int exp_g;
        do_reset();
        load_sources();
        req_valid = 4'b1111;
        db_ready  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_g = n % NSRC;
            #1;
            checks++;
            if (req_ready !== 4'(1 << exp_g)) begin
                failures++;
                $display("FAIL rr_req_ready[%0d] got=%b exp=%b", n, req_ready, 4'(1 << exp_g));
            end
            step();
            checks++;
            if (db_write !== 1'b1 || grant_id !== 2'(exp_g) || db_data !== sdata(exp_g)
                || db_dira !== saddr(exp_g)) begin
                failures++;
                $display("FAIL rr_grant[%0d] got write=%b gid=%0d data=%h exp 1/%0d/%h",
                         n, db_write, grant_id, db_data, exp_g, sdata(exp_g));
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        load_sources();
        req_valid = 4'b1000;
        db_ready  = 1'b1;
        step();
        req_valid = 4'b0010;
        db_ready  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || db_write !== 1'b1 || grant_id !== 2'd3
                || db_data !== sdata(3) || db_dira !== saddr(3)) begin
                failures++;
                $display("FAIL stall[%0d] got rdy=%b write=%b gid=%0d data=%h exp 0000/1/3/%h",
                         n, req_ready, db_write, grant_id, db_data, sdata(3));
            end
            step();
        end
        db_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL stall_release_ready got=%b exp=0010", req_ready);
        end
        step();
        req_valid = '0;
        #1;
        checks++;
        if (db_write !== 1'b1 || grant_id !== 2'd1 || db_data !== sdata(1)) begin
            failures++;
            $display("FAIL stall_release_out got write=%b gid=%0d data=%h exp 1/1/%h",
                     db_write, grant_id, db_data, sdata(1));
        end
        // A request withdrawn while the register is stalled must never be captured.
        req_valid = 4'b0100;
        db_ready  = 1'b0;
        step();
        req_valid = '0;
        db_ready  = 1'b1;
        step();
        checks++;
        if (db_write !== 1'b0 || grant_id !== 2'd1 || db_data !== sdata(1)) begin
            failures++;
            $display("FAIL withdrawn got write=%b gid=%0d data=%h exp 0/1/%h",
                     db_write, grant_id, db_data, sdata(1));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_sources();
        req_valid = 4'b0100;
        db_ready  = 1'b1;
        step();
        req_valid = '0;
        db_ready  = 1'b0;
        step();
        RST_N     = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_req_ready got=%b exp=0000", req_ready);
        end
        step();
        RST_N     = 1'b1;
        req_valid = '0;
        #1;
        checks++;
        if (db_write !== 1'b0 || db_data !== '0 || db_dira !== '0 || grant_id !== '0) begin
            failures++;
            $display("FAIL rstmid_out got write=%b data=%h dira=%h gid=%0d exp 0/0/0/0",
                     db_write, db_data, db_dira, grant_id);
        end
        // Pointer back at 0: source 0 wins over source 2.
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rstmid_ptr got=%b exp=0001", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_prio0();
`ifdef ROUTER_ARB_PRIO0_EN
        int exp_seq [4] = '{1, 2, 3, 1};
        do_reset();
        load_sources();
        req_valid = 4'b1111;
        db_ready  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            checks++;
            if (grant_id !== 2'd0) begin
                failures++;
                $display("FAIL prio0_grant[%0d] got=%0d exp=0", n, grant_id);
            end
        end
        req_valid = 4'b1110;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (grant_id !== 2'(exp_seq[n])) begin
                failures++;
                $display("FAIL prio0_rot[%0d] got=%0d exp=%0d", n, grant_id, exp_seq[n]);
            end
        end
        req_valid = '0;
        step();
`else
        // Without the option, source 0 gets no preference: pointer at 2 picks source 2.
        do_reset();
        load_sources();
        req_valid = 4'b0010;
        db_ready  = 1'b1;
        step();
        req_valid = 4'b0101;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL rr_no_prio got=%b exp=0100", req_ready);
        end
        req_valid = '0;
        step();
`endif
    endtask

    initial begin
        RST_N     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_addr  = '0;
        db_ready  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_prio0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
